// File: rtl/if_fetch.sv
// Instruction fetch stage: PC register, BOOT/RUN/HALT fetch FSM and the IF/ID pipeline register.
// Optional IF_FETCH_MISALIGN_CHK_EN refuses word-misaligned jump targets and reports them on misalign_o.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold_i,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        halt_i,
  input  logic        resume_i,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_inst_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o,
  output logic        halted_o,
`ifdef IF_FETCH_MISALIGN_CHK_EN
  output logic        misalign_o,
`endif
  output logic [31:0] fetch_cnt_o
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] pc_out_reg, pc_out_next;
  logic [31:0] inst_reg, inst_next;
  logic        valid_reg, valid_next;
  logic [31:0] cnt_reg, cnt_next;
  logic        misalign_reg, misalign_next;

  logic [31:0] jump_target;
  logic        jump_bad;

  // Low address bits are always dropped; the check build refuses such targets instead.
  assign jump_target = jump_addr_i & 32'hFFFF_FFFC;
`ifdef IF_FETCH_MISALIGN_CHK_EN
  assign jump_bad = |jump_addr_i[1:0];
`else
  assign jump_bad = 1'b0;
`endif

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    pc_out_next   = pc_out_reg;
    inst_next     = inst_reg;
    valid_next    = valid_reg;
    cnt_next      = cnt_reg;
    misalign_next = 1'b0;

    case (state_reg)
      ST_BOOT: begin
        state_next = ST_RUN;
        inst_next  = NOP_INST;
        valid_next = 1'b0;
      end

      ST_RUN, ST_HALT: begin
        if (jump_en_i) begin
          // Redirect wins over hold and halt; the wrong-path word is flushed.
          inst_next  = NOP_INST;
          valid_next = 1'b0;
          if (jump_bad) begin
            misalign_next = 1'b1;
          end else begin
            pc_next = jump_target;
          end
        end else if (hold_i) begin
          state_next = state_reg;
        end else if (state_reg == ST_RUN) begin
          if (halt_i) begin
            state_next = ST_HALT;
            inst_next  = NOP_INST;
            valid_next = 1'b0;
          end else begin
            pc_out_next = pc_reg;
            inst_next   = rom_inst_i;
            valid_next  = 1'b1;
            pc_next     = pc_reg + 32'd4;
            cnt_next    = cnt_reg + 32'd1;
          end
        end else begin
          inst_next  = NOP_INST;
          valid_next = 1'b0;
          if (resume_i && !halt_i) begin
            state_next = ST_RUN;
          end
        end
      end

      default: begin
        state_next = ST_BOOT;
        inst_next  = NOP_INST;
        valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_BOOT;
      pc_reg       <= RESET_PC;
      pc_out_reg   <= RESET_PC;
      inst_reg     <= NOP_INST;
      valid_reg    <= 1'b0;
      cnt_reg      <= 32'd0;
      misalign_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      pc_out_reg   <= pc_out_next;
      inst_reg     <= inst_next;
      valid_reg    <= valid_next;
      cnt_reg      <= cnt_next;
      misalign_reg <= misalign_next;
    end
  end

  assign rom_addr_o   = pc_reg;
  assign pc_o         = pc_out_reg;
  assign inst_o       = inst_reg;
  assign inst_valid_o = valid_reg;
  assign halted_o     = (state_reg == ST_HALT);
  assign fetch_cnt_o  = cnt_reg;

`ifdef IF_FETCH_MISALIGN_CHK_EN
  assign misalign_o = misalign_reg;
`else
  logic misalign_unused;
  assign misalign_unused = misalign_reg;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: per-cycle expectations queued at drive time and compared after each edge.
// A second instance with RESET_PC = 32'hFFFF_FFFC covers PC wrap and the misaligned-jump handling.
module tb_if_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, hold, jump_en, halt, resume;
  logic [31:0] jump_addr;
  logic [31:0] rom_addr, rom_inst, pc, inst, fetch_cnt;
  logic        inst_valid, halted;

  logic        rst_b, jump_en_b;
  logic [31:0] jump_addr_b;
  logic [31:0] rom_addr_b, rom_inst_b, pc_b, inst_b, fetch_cnt_b;
  logic        inst_valid_b, halted_b;
`ifdef IF_FETCH_MISALIGN_CHK_EN
  logic        misalign, misalign_b;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [31:0] cnt;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  // ROM word k = 32'h1000_0000 + k, k being the word index of the address
  assign rom_inst   = 32'h1000_0000 + (rom_addr >> 2);
  assign rom_inst_b = 32'h1000_0000 + (rom_addr_b >> 2);

  if_fetch #(.RESET_PC(32'h0000_0000), .NOP_INST(NOP)) u_dut (
    .clk(clk), .rst(rst), .hold_i(hold), .jump_en_i(jump_en), .jump_addr_i(jump_addr),
    .halt_i(halt), .resume_i(resume), .rom_addr_o(rom_addr), .rom_inst_i(rom_inst),
    .pc_o(pc), .inst_o(inst), .inst_valid_o(inst_valid), .halted_o(halted),
`ifdef IF_FETCH_MISALIGN_CHK_EN
    .misalign_o(misalign),
`endif
    .fetch_cnt_o(fetch_cnt)
  );

  if_fetch #(.RESET_PC(32'hFFFF_FFFC), .NOP_INST(NOP)) u_dut_b (
    .clk(clk), .rst(rst_b), .hold_i(1'b0), .jump_en_i(jump_en_b), .jump_addr_i(jump_addr_b),
    .halt_i(1'b0), .resume_i(1'b0), .rom_addr_o(rom_addr_b), .rom_inst_i(rom_inst_b),
    .pc_o(pc_b), .inst_o(inst_b), .inst_valid_o(inst_valid_b), .halted_o(halted_b),
`ifdef IF_FETCH_MISALIGN_CHK_EN
    .misalign_o(misalign_b),
`endif
    .fetch_cnt_o(fetch_cnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Push the expectation for the coming edge, clock it, then pop and compare.
  task automatic cyc(input string tag, input logic v, input logic [31:0] epc, input logic [31:0] ecnt);
    exp_t e;
    e.v = v; e.pc = epc; e.cnt = ecnt;
    sb_q.push_back(e);
    @(posedge clk); #1;
    e = sb_q.pop_front();
    chk({tag, ".valid"}, {31'b0, inst_valid}, {31'b0, e.v});
    if (e.v) begin
      chk({tag, ".pc"}, pc, e.pc);
      chk({tag, ".inst"}, inst, 32'h1000_0000 + (e.pc >> 2));
    end else begin
      chk({tag, ".nop"}, inst, NOP);
    end
    chk({tag, ".cnt"}, fetch_cnt, e.cnt);
    $display("cycle %s: pc=%h inst=%h valid=%0b cnt=%0d rom_addr=%h halted=%0b",
             tag, pc, inst, inst_valid, fetch_cnt, rom_addr, halted);
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0; jump_en = 1'b0; jump_addr = 32'h0; halt = 1'b0; resume = 1'b0;
    rst_b = 1'b1; jump_en_b = 1'b0; jump_addr_b = 32'h0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.pc", pc, 32'h0);
    chk("rst.inst", inst, NOP);
    chk("rst.valid", {31'b0, inst_valid}, 32'h0);
    chk("rst.cnt", fetch_cnt, 32'h0);
    chk("rst.halted", {31'b0, halted}, 32'h0);
    chk("rst.rom", rom_addr, 32'h0);

    // BOOT bubble, then free run of five words
    rst = 1'b0;
    cyc("boot", 1'b0, 32'h0, 32'd0);
    chk("boot.rom", rom_addr, 32'h0);
    cyc("run0", 1'b1, 32'h00, 32'd1);
    cyc("run1", 1'b1, 32'h04, 32'd2);
    cyc("run2", 1'b1, 32'h08, 32'd3);
    cyc("run3", 1'b1, 32'h0C, 32'd4);
    cyc("run4", 1'b1, 32'h10, 32'd5);

    // Hold three cycles at pc_o = 0x10
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc("hold", 1'b1, 32'h10, 32'd5);
      chk("hold.rom", rom_addr, 32'h14);
    end
    hold = 1'b0;
    cyc("unhold", 1'b1, 32'h14, 32'd6);

    // Jump to 8, then from PC = 8 jump to 0x40
    jump_en = 1'b1; jump_addr = 32'h08;
    cyc("jmp8", 1'b0, 32'h0, 32'd6);
    chk("jmp8.rom", rom_addr, 32'h08);
    jump_addr = 32'h40;
    cyc("jmp40", 1'b0, 32'h0, 32'd6);
    chk("jmp40.rom", rom_addr, 32'h40);
    jump_en = 1'b0;
    cyc("at40", 1'b1, 32'h40, 32'd7);

    // Hold together with jump: jump wins
    hold = 1'b1; jump_en = 1'b1; jump_addr = 32'h80;
    cyc("holdjmp", 1'b0, 32'h0, 32'd7);
    chk("holdjmp.rom", rom_addr, 32'h80);
    hold = 1'b0; jump_en = 1'b0;
    cyc("at80", 1'b1, 32'h80, 32'd8);

    // Halt at PC = 0x20 for four cycles, then resume
    jump_en = 1'b1; jump_addr = 32'h20;
    cyc("jmp20", 1'b0, 32'h0, 32'd8);
    jump_en = 1'b0; halt = 1'b1;
    cyc("halt0", 1'b0, 32'h0, 32'd8);
    chk("halt0.halted", {31'b0, halted}, 32'h1);
    chk("halt0.rom", rom_addr, 32'h20);
    halt = 1'b0;
    cyc("halt1", 1'b0, 32'h0, 32'd8);
    chk("halt1.halted", {31'b0, halted}, 32'h1);
    halt = 1'b1; resume = 1'b1;
    cyc("halt2", 1'b0, 32'h0, 32'd8);
    chk("halt2.halted", {31'b0, halted}, 32'h1);
    halt = 1'b0; resume = 1'b0;
    cyc("halt3", 1'b0, 32'h0, 32'd8);
    chk("halt3.halted", {31'b0, halted}, 32'h1);
    chk("halt3.rom", rom_addr, 32'h20);
    resume = 1'b1;
    cyc("resume", 1'b0, 32'h0, 32'd8);
    chk("resume.halted", {31'b0, halted}, 32'h0);
    resume = 1'b0;
    cyc("at20", 1'b1, 32'h20, 32'd9);

    // Jump to a misaligned target
    jump_en = 1'b1; jump_addr = 32'h42;
    cyc("jmp42", 1'b0, 32'h0, 32'd9);
    jump_en = 1'b0;
`ifdef IF_FETCH_MISALIGN_CHK_EN
    chk("jmp42.misalign", {31'b0, misalign}, 32'h1);
    chk("jmp42.rom", rom_addr, 32'h24);
    cyc("after42", 1'b1, 32'h24, 32'd10);
    chk("after42.misalign", {31'b0, misalign}, 32'h0);
`else
    chk("jmp42.rom", rom_addr, 32'h40);
    cyc("after42", 1'b1, 32'h40, 32'd10);
`endif

    // Reset overrides hold, jump and halt
    hold = 1'b1; jump_en = 1'b1; jump_addr = 32'h80; halt = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    chk("rst2.pc", pc, 32'h0);
    chk("rst2.rom", rom_addr, 32'h0);
    chk("rst2.valid", {31'b0, inst_valid}, 32'h0);
    chk("rst2.cnt", fetch_cnt, 32'h0);
    rst = 1'b0; hold = 1'b0; halt = 1'b0;
    cyc("boot2", 1'b0, 32'h0, 32'd0);
    chk("boot2.rom", rom_addr, 32'h0);
    jump_en = 1'b0;
    cyc("rerun0", 1'b1, 32'h00, 32'd1);

    // Reset during HALT
    halt = 1'b1;
    cyc("halt4", 1'b0, 32'h0, 32'd1);
    chk("halt4.halted", {31'b0, halted}, 32'h1);
    halt = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    chk("rst3.halted", {31'b0, halted}, 32'h0);
    chk("rst3.rom", rom_addr, 32'h0);
    chk("rst3.cnt", fetch_cnt, 32'h0);
    rst = 1'b0;

    // High RESET_PC instance: PC wrap and misaligned jump
    rst_b = 1'b0;
    @(posedge clk); #1;
    chk("b.boot.valid", {31'b0, inst_valid_b}, 32'h0);
    chk("b.boot.rom", rom_addr_b, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    chk("b.w0.pc", pc_b, 32'hFFFF_FFFC);
    chk("b.w0.inst", inst_b, 32'h4FFF_FFFF);
    $display("b cycle w0: pc=%h inst=%h valid=%0b", pc_b, inst_b, inst_valid_b);
    @(posedge clk); #1;
    chk("b.w1.pc", pc_b, 32'h0);
    chk("b.w1.inst", inst_b, 32'h1000_0000);
    chk("b.w1.cnt", fetch_cnt_b, 32'd2);
    $display("b cycle w1: pc=%h inst=%h valid=%0b", pc_b, inst_b, inst_valid_b);
    jump_en_b = 1'b1; jump_addr_b = 32'h42;
    @(posedge clk); #1;
    jump_en_b = 1'b0;
    chk("b.jmp.valid", {31'b0, inst_valid_b}, 32'h0);
`ifdef IF_FETCH_MISALIGN_CHK_EN
    chk("b.jmp.misalign", {31'b0, misalign_b}, 32'h1);
    chk("b.jmp.rom", rom_addr_b, 32'h4);
`else
    chk("b.jmp.rom", rom_addr_b, 32'h40);
`endif
    $display("b cycle jmp: rom_addr=%h valid=%0b", rom_addr_b, inst_valid_b);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
